pb_debounce_bank: RTL

Parametrised multi-channel push-button debouncer. It synchronises CHANNELS raw button or switch inputs, filters each one independently with a saturating stability counter, and produces a clean level plus single-cycle press and release strobes per channel. A compile-time option adds hold-to-repeat strobes. It sits between the board pins and the filter control logic, which uses it for coefficient stepping, mode selection and step-size adjustment.

---
 rtl/pb_debounce_bank.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/pb_debounce_bank.sv
// -----------------------------------------------------------------------------
// pb_debounce_bank
//
// Multi-channel push-button debouncer. Each of CHANNELS raw pins is
// polarity-normalised (INVERT mask bit 1 = active-low pin). It then passes
// through a two-flop synchroniser and is filtered by a saturating stability
// counter. The debounced level changes only after the synchronised input has
// disagreed with it for 2^CNT_W consecutive cycles.
//
// Optional feature macro: PB_DEBOUNCE_REPEAT_EN
//   defined   -> per-channel hold-to-repeat counters drive pb_repeat
//   undefined -> pb_repeat is tied to 0 and the RPT_* parameters are unused
//
// Ports
//   clk       : system clock, all state on the rising edge
//   rst_n     : asynchronous active-low reset (release assumed synchronous)
//   pb_in     : raw asynchronous button pins
//   pb_state  : debounced level, 1 = pressed (registered)
//   pb_down   : one-cycle strobe on each accepted press (registered)
//   pb_up     : one-cycle strobe on each accepted release (registered)
//   pb_repeat : one-cycle hold-repeat strobe (registered)
// -----------------------------------------------------------------------------
module pb_debounce_bank #(
   parameter int                   CHANNELS   = 4,
   parameter int                   CNT_W      = 16,
   parameter logic [CHANNELS-1:0]  INVERT     = {CHANNELS{1'b0}},
   parameter int                   RPT_W      = 24,
   parameter logic [RPT_W-1:0]     RPT_FIRST  = 24'd12_000_000,
   parameter logic [RPT_W-1:0]     RPT_PERIOD = 24'd3_000_000
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [CHANNELS-1:0] pb_in,
   output logic [CHANNELS-1:0] pb_state,
   output logic [CHANNELS-1:0] pb_down,
   output logic [CHANNELS-1:0] pb_up,
   output logic [CHANNELS-1:0] pb_repeat
);

   // One step of the stability counter. Returns {toggle, next_count}.
   // The counter clears on agreement and never wraps: when it is all-ones
   // and the mismatch persists, the level toggles and the count restarts.
   function automatic logic [CNT_W:0] stab_step(input logic             mismatch,
                                                input logic [CNT_W-1:0] cnt);
      logic [CNT_W:0] r;
      if (!mismatch) begin
         r = {1'b0, {CNT_W{1'b0}}};
      end else if (cnt == {CNT_W{1'b1}}) begin
         r = {1'b1, {CNT_W{1'b0}}};
      end else begin
         r = {1'b0, cnt + {{(CNT_W-1){1'b0}}, 1'b1}};
      end
      return r;
   endfunction

   logic [CHANNELS-1:0] lvl;
   logic [CHANNELS-1:0] sync0_q, sync1_q;
   logic [CHANNELS-1:0] state_q, state_d;
   logic [CHANNELS-1:0] down_q, down_d;
   logic [CHANNELS-1:0] up_q, up_d;
   logic [CHANNELS-1:0] tog;
   logic [CNT_W-1:0]    cnt_q [CHANNELS];
   logic [CNT_W-1:0]    cnt_d [CHANNELS];

   // Normalise polarity so that 1 always means pressed.
   assign lvl = pb_in ^ INVERT;

   always_comb begin
      state_d = state_q;
      down_d  = '0;
      up_d    = '0;
      tog     = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         {tog[i], cnt_d[i]} = stab_step(sync1_q[i] ^ state_q[i], cnt_q[i]);
         if (tog[i]) begin
            state_d[i] = ~state_q[i];
            down_d[i]  = ~state_q[i];
            up_d[i]    = state_q[i];
         end
      end
   end

   // Stage: synchroniser, stability counter, debounced level and strobes
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync0_q <= '0;
         sync1_q <= '0;
         state_q <= '0;
         down_q  <= '0;
         up_q    <= '0;
         for (int i = 0; i < CHANNELS; i++) begin
            cnt_q[i] <= '0;
         end
      end else begin
         sync0_q <= lvl;
         sync1_q <= sync0_q;
         state_q <= state_d;
         down_q  <= down_d;
         up_q    <= up_d;
         for (int i = 0; i < CHANNELS; i++) begin
            cnt_q[i] <= cnt_d[i];
         end
      end
   end

   assign pb_state = state_q;
   assign pb_down  = down_q;
   assign pb_up    = up_q;

`ifdef PB_DEBOUNCE_REPEAT_EN
   // The repeat counter counts up to the current target (RPT_FIRST before the
   // first repeat, RPT_PERIOD afterwards) and restarts from 0 on each repeat,
   // so it never needs to exceed max(RPT_FIRST, RPT_PERIOD).
   logic [RPT_W-1:0]    rpt_cnt_q [CHANNELS];
   logic [RPT_W-1:0]    rpt_cnt_d [CHANNELS];
   logic [CHANNELS-1:0] rpt_first_q, rpt_first_d;
   logic [CHANNELS-1:0] rpt_q, rpt_d;

   always_comb begin
      logic [RPT_W-1:0] inc;
      logic [RPT_W-1:0] tgt;
      inc         = '0;
      tgt         = '0;
      rpt_first_d = rpt_first_q;
      rpt_d       = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         rpt_cnt_d[i] = rpt_cnt_q[i];
         if (!state_q[i] && state_d[i]) begin
            // press edge: start timing from 0
            rpt_cnt_d[i]   = '0;
            rpt_first_d[i] = 1'b0;
         end else if (state_q[i] && state_d[i]) begin
            inc = rpt_cnt_q[i] + {{(RPT_W-1){1'b0}}, 1'b1};
            tgt = rpt_first_q[i] ? RPT_PERIOD : RPT_FIRST;
            if (inc == tgt) begin
               rpt_d[i]       = 1'b1;
               rpt_cnt_d[i]   = '0;
               rpt_first_d[i] = 1'b1;
            end else begin
               rpt_cnt_d[i] = inc;
            end
         end else begin
            // released or releasing this edge: no repeat, counter idle
            rpt_cnt_d[i]   = '0;
            rpt_first_d[i] = 1'b0;
         end
      end
   end

   // Stage: hold-repeat counters and strobe
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rpt_first_q <= '0;
         rpt_q       <= '0;
         for (int i = 0; i < CHANNELS; i++) begin
            rpt_cnt_q[i] <= '0;
         end
      end else begin
         rpt_first_q <= rpt_first_d;
         rpt_q       <= rpt_d;
         for (int i = 0; i < CHANNELS; i++) begin
            rpt_cnt_q[i] <= rpt_cnt_d[i];
         end
      end
   end

   assign pb_repeat = rpt_q;
`else
   logic unused_rpt;
   assign unused_rpt = ^{RPT_FIRST, RPT_PERIOD};
   assign pb_repeat  = '0;
`endif

endmodule
